// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// beat-counter width helper used by the top level.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold values 0..N where N = width/bpc beats per addition.
    function automatic int cnt_width(input int width, input int bpc);
        return $clog2(width / bpc) + 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; chained inside serial_adder to form the per-beat adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands BPC bits per clock,
// LSB-first, through a ripple chain of fa_cell instances.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow
// output ovf, registered alongside sum.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = cnt_width(WIDTH, BPC);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [BPC-1:0]   beat_sum;
    logic [BPC:0]     chain;
    logic [WIDTH-1:0] beat_ext;
    logic [WIDTH-1:0] next_acc;
    logic             accept;

`ifdef SERIAL_ADDER_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // Operand bits are consumed from the bottom of the shift registers; the
    // carry register feeds the bottom of the ripple chain each beat.
    assign chain[0] = carry;

    for (genvar i = 0; i < BPC; i++) begin : g_fa
        fa_cell u_fa (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .cin  (chain[i]),
            .sum  (beat_sum[i]),
            .cout (chain[i+1])
        );
    end

    // Sum bits enter the accumulator from the top, so after N beats the
    // first beat's bits have reached the LSB end.
    assign beat_ext = WIDTH'(beat_sum);
    assign next_acc = (acc >> BPC) | (beat_ext << (WIDTH - BPC));

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Control FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            state <= RUN;
            cnt   <= '0;
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            carry <= cin;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else begin
            case (state)
                RUN: begin
                    a_sh  <= a_sh >> BPC;
                    b_sh  <= b_sh >> BPC;
                    acc   <= next_acc;
                    carry <= chain[BPC];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_BEAT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= next_acc;
                        cout  <= chain[BPC];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= (a_msb == b_msb) && (next_acc[WIDTH-1] != a_msb);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: one instance with BPC=1 and one
// with BPC=4 (both WIDTH=8), compared against plain-arithmetic expectations.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start4;
    logic [7:0] a1, b1, a4, b4;
    logic       cin1, cin4;
    logic       busy1, busy4, done1, done4, cout1, cout4;
    logic [7:0] sum1, sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf1, ovf4;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BPC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout1), .ovf(ovf1)
`else
        .cout(cout1)
`endif
    );

    serial_adder #(.WIDTH(8), .BPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout4), .ovf(ovf4)
`else
        .cout(cout4)
`endif
    );

    // Called at a falling edge. Pulses start for one cycle on the chosen
    // instance, then waits for done. done_edge counts the accepting edge as
    // edge 1; busy_cnt counts sampled cycles with busy high. done_edge stays
    // -1 if done never arrives within the budget.
    task automatic do_op(input int sel, input logic [7:0] oa, input logic [7:0] ob,
                         input logic oc, output int done_edge, output int busy_cnt);
        if (sel == 1) begin a1 = oa; b1 = ob; cin1 = oc; start1 = 1'b1; end
        else          begin a4 = oa; b4 = ob; cin4 = oc; start4 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom); a4 = 8'($urandom); b4 = 8'($urandom);
        done_edge = -1;
        busy_cnt  = 0;
        for (int k = 0; k < 40; k++) begin
            if ((sel == 1) ? busy1 : busy4) busy_cnt++;
            if ((sel == 1) ? done1 : done4) begin
                done_edge = k + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
        a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0; a4 = 8'h00; b4 = 8'h00; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy1, done1, cout1, sum1} !== 11'd0)
            begin fails++; $display("[TB] FAIL reset_dut1: got %h expected 0", {busy1, done1, cout1, sum1}); end
        checks++; if ({busy4, done4, cout4, sum4} !== 11'd0)
            begin fails++; $display("[TB] FAIL reset_dut4: got %h expected 0", {busy4, done4, cout4, sum4}); end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if ({ovf1, ovf4} !== 2'b00)
            begin fails++; $display("[TB] FAIL reset_ovf: got %b expected 00", {ovf1, ovf4}); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bpc1_carry();
        int de, bc;
        do_op(1, 8'hFF, 8'h01, 1'b0, de, bc);
        checks++; if (de !== 9)    begin fails++; $display("[TB] FAIL bpc1_done_edge: got %0d expected 9", de); end
        checks++; if (sum1 !== 8'h00) begin fails++; $display("[TB] FAIL bpc1_sum: got %h expected 00", sum1); end
        checks++; if (cout1 !== 1'b1) begin fails++; $display("[TB] FAIL bpc1_cout: got %b expected 1", cout1); end
        checks++; if (bc !== 8)    begin fails++; $display("[TB] FAIL bpc1_busy_cycles: got %0d expected 8", bc); end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin fails++; $display("[TB] FAIL bpc1_done_width: got %b expected 0", done1); end
        checks++; if (sum1 !== 8'h00 || cout1 !== 1'b1)
            begin fails++; $display("[TB] FAIL bpc1_hold: got %h/%b expected 00/1", sum1, cout1); end
    endtask

    task automatic test_bpc4();
        int de, bc;
        do_op(4, 8'h3C, 8'h5A, 1'b1, de, bc);
        checks++; if (de !== 3)       begin fails++; $display("[TB] FAIL bpc4_done_edge: got %0d expected 3", de); end
        checks++; if (sum4 !== 8'h97) begin fails++; $display("[TB] FAIL bpc4_sum: got %h expected 97", sum4); end
        checks++; if (cout4 !== 1'b0) begin fails++; $display("[TB] FAIL bpc4_cout: got %b expected 0", cout4); end
        checks++; if (bc !== 2)       begin fails++; $display("[TB] FAIL bpc4_busy_cycles: got %0d expected 2", bc); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int de, bc, sel, n;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp_full;
        for (int i = 0; i < 16; i++) begin
            sel = (i % 2 == 0) ? 1 : 4;
            n   = 8 / sel;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            exp_full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_op(sel, ra, rb, rc, de, bc);
            checks++; if (de !== n + 1)
                begin fails++; $display("[TB] FAIL rand_done_edge[%0d]: got %0d expected %0d", i, de, n + 1); end
            checks++; if (((sel == 1) ? {cout1, sum1} : {cout4, sum4}) !== exp_full)
                begin fails++; $display("[TB] FAIL rand_result[%0d]: got %h expected %h (a=%h b=%h cin=%b)",
                    i, (sel == 1) ? {cout1, sum1} : {cout4, sum4}, exp_full, ra, rb, rc); end
`ifdef SERIAL_ADDER_OVF_EN
            checks++; if (((sel == 1) ? ovf1 : ovf4) !== ((ra[7] == rb[7]) && (exp_full[7] != ra[7])))
                begin fails++; $display("[TB] FAIL rand_ovf[%0d]: got %b expected %b", i,
                    (sel == 1) ? ovf1 : ovf4, (ra[7] == rb[7]) && (exp_full[7] != ra[7])); end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        logic [7:0] first_sum;
        a1 = 8'h12; b1 = 8'h34; cin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        a1 = 8'h00; b1 = 8'h00; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        pulses = 0;
        first_sum = 8'hxx;
        for (int k = 0; k < 16; k++) begin
            if (done1) begin
                pulses++;
                if (pulses == 1) first_sum = sum1;
            end
            @(negedge clk);
        end
        checks++; if (pulses !== 1)       begin fails++; $display("[TB] FAIL ignore_pulses: got %0d expected 1", pulses); end
        checks++; if (first_sum !== 8'h46) begin fails++; $display("[TB] FAIL ignore_sum: got %h expected 46", first_sum); end
        checks++; if (sum1 !== 8'h46 || cout1 !== 1'b0)
            begin fails++; $display("[TB] FAIL ignore_hold: got %h/%b expected 46/0", sum1, cout1); end
    endtask

    task automatic test_back_to_back();
        int de, bc;
        do_op(1, 8'hA5, 8'h6B, 1'b1, de, bc);
        checks++; if ({cout1, sum1} !== 9'h111)
            begin fails++; $display("[TB] FAIL b2b_first: got %h expected 111", {cout1, sum1}); end
        a1 = 8'h10; b1 = 8'h20; cin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0)
            begin fails++; $display("[TB] FAIL b2b_immediate_run: got busy=%b done=%b expected 1/0", busy1, done1); end
        checks++; if (sum1 !== 8'h11)
            begin fails++; $display("[TB] FAIL b2b_hold_during_run: got %h expected 11", sum1); end
        de = -1;
        for (int k = 0; k < 40; k++) begin
            if (done1) begin de = k + 1; break; end
            @(negedge clk);
        end
        checks++; if (de !== 9)       begin fails++; $display("[TB] FAIL b2b_done_edge: got %0d expected 9", de); end
        checks++; if (sum1 !== 8'h30 || cout1 !== 1'b0)
            begin fails++; $display("[TB] FAIL b2b_second: got %h/%b expected 30/0", sum1, cout1); end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int pulses, de, bc;
        a1 = 8'h55; b1 = 8'h0F; cin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy1, done1, cout1, sum1} !== 11'd0)
            begin fails++; $display("[TB] FAIL midrun_reset_outputs: got %h expected 0", {busy1, done1, cout1, sum1}); end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1) pulses++;
        end
        checks++; if (pulses !== 0) begin fails++; $display("[TB] FAIL midrun_no_done: got %0d expected 0", pulses); end
        rst_n = 1'b1;
        do_op(1, 8'h55, 8'h0F, 1'b0, de, bc);
        checks++; if (de !== 9)       begin fails++; $display("[TB] FAIL midrun_after_edge: got %0d expected 9", de); end
        checks++; if (sum1 !== 8'h64 || cout1 !== 1'b0)
            begin fails++; $display("[TB] FAIL midrun_after_sum: got %h/%b expected 64/0", sum1, cout1); end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int de, bc;
        do_op(1, 8'h7F, 8'h01, 1'b0, de, bc);
        checks++; if (ovf1 !== 1'b1 || sum1 !== 8'h80)
            begin fails++; $display("[TB] FAIL ovf_pos: got %b/%h expected 1/80", ovf1, sum1); end
        @(negedge clk);
        do_op(1, 8'hFF, 8'h01, 1'b0, de, bc);
        checks++; if (ovf1 !== 1'b0 || sum1 !== 8'h00)
            begin fails++; $display("[TB] FAIL ovf_neg: got %b/%h expected 0/00", ovf1, sum1); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_bpc1_carry();
        test_bpc4();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
